playback_timer: RTL and testbench



---
 rtl/player_pkg.sv | 42 ++++
 rtl/mmss_converter.sv | 70 +++++++
 rtl/playback_timer.sv | 104 ++++++++++
 tb/tb_playback_timer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared types and constants for the playback timer and its digit converter
package player_pkg;

  typedef enum logic [1:0] {
    SPD_1X     = 2'd0,
    SPD_2X     = 2'd1,
    SPD_HALF   = 2'd2,
    SPD_1X_ALT = 2'd3
  } speed_e;

  typedef enum logic [1:0] {
    CONV_IDLE = 2'd0,
    CONV_MIN  = 2'd1,
    CONV_TENS = 2'd2,
    CONV_DONE = 2'd3
  } conv_state_e;

  localparam logic [2:0] STEP_1X     = 3'd2;
  localparam logic [2:0] STEP_2X     = 3'd4;
  localparam logic [2:0] STEP_HALF   = 3'd1;
  localparam logic [2:0] STEP_1X_ALT = 3'd2;

  localparam int POS_FRAC_BITS = 4;
  localparam int POS_W         = 14;
  localparam int SEC_W         = 10;

  localparam logic [SEC_W-1:0] MAX_SONG_SEC = 10'd599;
  localparam logic [SEC_W-1:0] SEC_60       = 10'd60;
  localparam logic [SEC_W-1:0] SEC_120      = 10'd120;
  localparam logic [SEC_W-1:0] SEC_10       = 10'd10;
  localparam logic [SEC_W-1:0] SEC_20       = 10'd20;

  function automatic logic [2:0] step_for(input logic [1:0] spd);
    case (spd)
      SPD_2X:     return STEP_2X;
      SPD_HALF:   return STEP_HALF;
      SPD_1X_ALT: return STEP_1X_ALT;
      default:    return STEP_1X;
    endcase
  endfunction

endpackage

// File: rtl/mmss_converter.sv
// rtl/mmss_converter.sv - iterative seconds to m:ss digit converter, digits updated atomically
module mmss_converter
  import player_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [SEC_W-1:0] sec_in_i,
  output logic             busy_o,
  output logic [3:0]       min_d_o,
  output logic [3:0]       sec_t_o,
  output logic [3:0]       sec_o_o
);

  conv_state_e      state_q;
  logic [SEC_W-1:0] last_q;
  logic [SEC_W-1:0] rem_q;
  logic [3:0]       min_q;
  logic [3:0]       tens_q;

  assign busy_o = (state_q != CONV_IDLE);

  // Each subtract stage leaves on the same cycle as its last subtraction,
  // so the worst case (599) completes in 16 cycles from the latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CONV_IDLE;
      last_q  <= '0;
      rem_q   <= '0;
      min_q   <= '0;
      tens_q  <= '0;
      min_d_o <= '0;
      sec_t_o <= '0;
      sec_o_o <= '0;
    end else begin
      case (state_q)
        CONV_IDLE: begin
          if (start_i && (sec_in_i != last_q)) begin
            last_q  <= sec_in_i;
            rem_q   <= (sec_in_i > MAX_SONG_SEC) ? MAX_SONG_SEC : sec_in_i;
            min_q   <= '0;
            tens_q  <= '0;
            state_q <= CONV_MIN;
          end
        end
        CONV_MIN: begin
          if (rem_q >= SEC_60) begin
            rem_q <= rem_q - SEC_60;
            min_q <= min_q + 4'd1;
          end
          if (rem_q < SEC_120) state_q <= CONV_TENS;
        end
        CONV_TENS: begin
          if (rem_q >= SEC_10) begin
            rem_q  <= rem_q - SEC_10;
            tens_q <= tens_q + 4'd1;
          end
          if (rem_q < SEC_20) state_q <= CONV_DONE;
        end
        CONV_DONE: begin
          min_d_o <= min_q;
          sec_t_o <= tens_q;
          sec_o_o <= rem_q[3:0];
          state_q <= CONV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/playback_timer.sv
// rtl/playback_timer.sv - song position tracker: tick divider, seeks, end-of-song detection, mm:ss digits
module playback_timer
  import player_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_DIV = CLK_HZ / 8,
  parameter int SEEK_SEC = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             play_i,
  input  logic             song_change_i,
  input  logic             forward_i,
  input  logic             backward_i,
  input  logic             repeat_i,
  input  logic [1:0]       speed_i,
  input  logic [SEC_W-1:0] song_len_i,
  output logic             playing_o,
  output logic             song_finished_o,
  output logic [SEC_W-1:0] elapsed_sec_o,
  output logic [3:0]       min_d_o,
  output logic [3:0]       sec_t_o,
  output logic [3:0]       sec_o_o
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [POS_W:0]   SEEK_POS = (POS_W + 1)'(SEEK_SEC << POS_FRAC_BITS);

  logic [DIV_W-1:0] div_q, div_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             playing_q, playing_d;
  logic             finished_q, finished_d;

  logic             tick;
  logic             upd;
  logic             at_end;
  logic [POS_W:0]   pos_upd;

  // The divider keeps running through a seek; only the tick's step is lost.
  always_comb begin
    tick    = playing_q && (div_q == DIV_LAST);
    div_d   = div_q;
    if (playing_q) div_d = tick ? '0 : div_q + DIV_W'(1);

    upd     = 1'b0;
    pos_upd = {1'b0, pos_q};
    if (forward_i && !backward_i) begin
      upd     = 1'b1;
      pos_upd = {1'b0, pos_q} + SEEK_POS;
    end else if (backward_i && !forward_i) begin
      upd     = 1'b1;
      pos_upd = ({1'b0, pos_q} >= SEEK_POS) ? ({1'b0, pos_q} - SEEK_POS) : '0;
    end else if (tick) begin
      upd     = 1'b1;
      pos_upd = {1'b0, pos_q} + (POS_W + 1)'(step_for(speed_i));
    end

    at_end     = upd && (pos_upd[POS_W:POS_FRAC_BITS] >= {1'b0, song_len_i});
    pos_d      = pos_upd[POS_W-1:0];
    finished_d = 1'b0;
    if (song_change_i) begin
      pos_d = '0;
      div_d = '0;
    end else if (at_end) begin
      pos_d      = '0;
      div_d      = '0;
      finished_d = !repeat_i;
    end

    playing_d = playing_q ^ play_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      pos_q      <= '0;
      playing_q  <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pos_q      <= pos_d;
      playing_q  <= playing_d;
      finished_q <= finished_d;
    end
  end

  assign playing_o       = playing_q;
  assign song_finished_o = finished_q;
  assign elapsed_sec_o   = pos_q[POS_W-1:POS_FRAC_BITS];

  // The converter tracks its own last value, so it may be requested every cycle.
  mmss_converter u_conv (
    .clock    (clock),
    .reset    (reset),
    .start_i  (1'b1),
    .sec_in_i (elapsed_sec_o),
    .busy_o   (),
    .min_d_o  (min_d_o),
    .sec_t_o  (sec_t_o),
    .sec_o_o  (sec_o_o)
  );

endmodule

// File: tb/tb_playback_timer.sv
// tb/tb_playback_timer.sv - self-checking bench for playback_timer with a behavioural position model
module tb_playback_timer;

  localparam int TD = 4;
  localparam int SEEK = 5;

  logic       clock, reset;
  logic       play, song_change, forward, backward, rep;
  logic [1:0] speed;
  logic [9:0] song_len;
  logic       playing, song_finished;
  logic [9:0] elapsed_sec;
  logic [3:0] min_d, sec_t, sec_o;

  int checks = 0;
  int failures = 0;

  int m_pos, m_div;
  bit m_playing, m_fin;

  playback_timer #(.CLK_HZ(32), .TICK_DIV(TD), .SEEK_SEC(SEEK)) dut (
    .clock(clock), .reset(reset), .play_i(play), .song_change_i(song_change),
    .forward_i(forward), .backward_i(backward), .repeat_i(rep), .speed_i(speed),
    .song_len_i(song_len), .playing_o(playing), .song_finished_o(song_finished),
    .elapsed_sec_o(elapsed_sec), .min_d_o(min_d), .sec_t_o(sec_t), .sec_o_o(sec_o)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  function automatic int step_of(input logic [1:0] s);
    case (s)
      2'd1: return 4;
      2'd2: return 1;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0; m_div = 0; m_playing = 0; m_fin = 0;
  endtask

  task automatic model_step();
    bit tick, moved;
    tick  = m_playing && (m_div == TD - 1);
    m_fin = 0;
    if (m_playing) m_div = tick ? 0 : m_div + 1;
    if (song_change) begin
      m_pos = 0; m_div = 0;
    end else begin
      moved = 1;
      if (forward && !backward) m_pos = m_pos + SEEK * 16;
      else if (backward && !forward) m_pos = (m_pos >= SEEK * 16) ? m_pos - SEEK * 16 : 0;
      else if (tick) m_pos = m_pos + step_of(speed);
      else moved = 0;
      if (moved && (m_pos / 16 >= int'(song_len))) begin
        m_pos = 0; m_div = 0; m_fin = !rep;
      end
    end
    if (play) m_playing = !m_playing;
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    play = 0; song_change = 0; forward = 0; backward = 0;
  endtask

  task automatic test_reset();
    reset = 1; play = 0; song_change = 0; forward = 0; backward = 0;
    rep = 0; speed = 0; song_len = 10'd3;
    #12;
    checks++;
    if ({playing, song_finished, elapsed_sec, min_d, sec_t, sec_o} !== 24'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", {playing, song_finished, elapsed_sec, min_d, sec_t, sec_o});
    end
    @(posedge clock); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_play_end();
    int exp_el;
    song_len = 10'd3; speed = 2'd0; rep = 0;
    play = 1; cyc();
    checks++;
    if (playing !== 1'b1) begin failures++; $display("FAIL play_toggle got=%b exp=1", playing); end
    for (int k = 1; k <= 100; k++) begin
      cyc();
      exp_el = (k < 96) ? k / 32 : 0;
      checks++;
      if (elapsed_sec !== 10'(exp_el) || song_finished !== (k == 96)) begin
        failures++;
        $display("FAIL play_end k=%0d got el=%0d fin=%b exp el=%0d fin=%b", k, elapsed_sec, song_finished, exp_el, k == 96);
      end
    end
    checks++;
    if (playing !== 1'b1) begin failures++; $display("FAIL play_after_end got=%b exp=1", playing); end
  endtask

  task automatic test_repeat();
    int exp_el;
    rep = 1; song_change = 1; cyc();
    for (int k = 1; k <= 110; k++) begin
      cyc();
      exp_el = (k < 96) ? k / 32 : 0;
      checks++;
      if (elapsed_sec !== 10'(exp_el) || song_finished !== 1'b0) begin
        failures++;
        $display("FAIL repeat k=%0d got el=%0d fin=%b exp el=%0d fin=0", k, elapsed_sec, song_finished, exp_el);
      end
    end
    rep = 0;
  endtask

  task automatic test_speed();
    song_len = 10'd599; speed = 2'd1; song_change = 1; cyc();
    for (int k = 1; k <= 40; k++) begin
      cyc();
      checks++;
      if (elapsed_sec !== 10'(k / 16)) begin
        failures++; $display("FAIL speed_2x k=%0d got=%0d exp=%0d", k, elapsed_sec, k / 16);
      end
    end
    speed = 2'd2; song_change = 1; cyc();
    for (int k = 1; k <= 130; k++) begin
      cyc();
      checks++;
      if (elapsed_sec !== 10'(k / 64)) begin
        failures++; $display("FAIL speed_half k=%0d got=%0d exp=%0d", k, elapsed_sec, k / 64);
      end
    end
    speed = 2'd0;
  endtask

  task automatic test_seek();
    song_change = 1; cyc();
    for (int k = 1; k <= 64; k++) cyc();
    play = 1; cyc();
    repeat (5) cyc();
    checks++;
    if (playing !== 1'b0 || elapsed_sec !== 10'd2) begin
      failures++; $display("FAIL paused_at_2 got play=%b el=%0d exp play=0 el=2", playing, elapsed_sec);
    end
    backward = 1; cyc();
    checks++;
    if (elapsed_sec !== 10'd0) begin failures++; $display("FAIL backward_sat got=%0d exp=0", elapsed_sec); end
    song_len = 10'd8;
    forward = 1; cyc();
    checks++;
    if (elapsed_sec !== 10'd5 || song_finished !== 1'b0) begin
      failures++; $display("FAIL forward_1 got el=%0d fin=%b exp el=5 fin=0", elapsed_sec, song_finished);
    end
    forward = 1; cyc();
    checks++;
    if (elapsed_sec !== 10'd0 || song_finished !== 1'b1 || playing !== 1'b0) begin
      failures++; $display("FAIL forward_end got el=%0d fin=%b play=%b exp el=0 fin=1 play=0", elapsed_sec, song_finished, playing);
    end
    cyc();
    checks++;
    if (song_finished !== 1'b0) begin failures++; $display("FAIL fin_one_cycle got=%b exp=0", song_finished); end
  endtask

  task automatic test_conflicts();
    forward = 1; cyc();
    forward = 1; backward = 1; cyc();
    checks++;
    if (elapsed_sec !== 10'd5) begin failures++; $display("FAIL fwd_bwd_cancel got=%0d exp=5", elapsed_sec); end
    song_change = 1; forward = 1; cyc();
    checks++;
    if (elapsed_sec !== 10'd0 || song_finished !== 1'b0) begin
      failures++; $display("FAIL change_beats_seek got el=%0d fin=%b exp el=0 fin=0", elapsed_sec, song_finished);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      play        = ($urandom % 40) == 0;
      song_change = ($urandom % 97) == 0;
      forward     = ($urandom % 25) == 0;
      backward    = ($urandom % 25) == 0;
      if (($urandom % 200) == 0) speed = 2'($urandom % 4);
      if (($urandom % 200) == 0) rep = 1'($urandom % 2);
      if (($urandom % 150) == 0) song_len = 10'($urandom_range(1, 20));
      cyc();
      checks++;
      if (playing !== m_playing || song_finished !== m_fin || elapsed_sec !== 10'(m_pos / 16)) begin
        failures++;
        if (failures < 20)
          $display("FAIL random n=%0d got play=%b fin=%b el=%0d exp play=%b fin=%b el=%0d",
                   n, playing, song_finished, elapsed_sec, m_playing, m_fin, m_pos / 16);
      end
    end
    if (m_playing) begin play = 1; cyc(); end
    repeat (40) cyc();
    checks++;
    if (min_d !== 4'(m_pos / 16 / 60) || sec_t !== 4'((m_pos / 16 % 60) / 10) || sec_o !== 4'(m_pos / 16 % 10)) begin
      failures++; $display("FAIL random_digits got=%0d:%0d%0d for el=%0d", min_d, sec_t, sec_o, m_pos / 16);
    end
  endtask

  task automatic test_digits();
    int first_k;
    logic [11:0] t;
    rep = 0; song_len = 10'd599; song_change = 1; cyc();
    for (int i = 0; i < 26; i++) begin forward = 1; cyc(); cyc(); end
    repeat (40) cyc();
    checks++;
    if (elapsed_sec !== 10'd130 || {min_d, sec_t, sec_o} !== 12'h210) begin
      failures++; $display("FAIL digits_130 got el=%0d d=%h exp el=130 d=210", elapsed_sec, {min_d, sec_t, sec_o});
    end
    backward = 1; cyc();
    first_k = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      t = {min_d, sec_t, sec_o};
      checks++;
      if (t !== 12'h210 && t !== 12'h205) begin
        failures++; $display("FAIL digits_partial k=%0d got=%h exp=210 or 205", k, t);
      end
      if (t === 12'h205 && first_k == 0) first_k = k;
    end
    checks++;
    if (first_k < 1 || first_k > 17) begin
      failures++; $display("FAIL digits_latency got=%0d exp=1..17", first_k);
    end
    song_len = 10'd1023;
    for (int i = 0; i < 96; i++) begin forward = 1; cyc(); cyc(); end
    repeat (40) cyc();
    checks++;
    if (elapsed_sec !== 10'd605 || {min_d, sec_t, sec_o} !== 12'h959) begin
      failures++; $display("FAIL digits_clamp got el=%0d d=%h exp el=605 d=959", elapsed_sec, {min_d, sec_t, sec_o});
    end
  endtask

  task automatic test_reset_mid_conv();
    backward = 1; cyc();
    cyc(); cyc();
    checks++;
    if (dut.u_conv.busy_o !== 1'b1) begin failures++; $display("FAIL conv_busy got=%b exp=1", dut.u_conv.busy_o); end
    reset = 1;
    #2;
    checks++;
    if ({min_d, sec_t, sec_o} !== 12'h000 || dut.u_conv.busy_o !== 1'b0 || elapsed_sec !== 10'd0) begin
      failures++; $display("FAIL reset_mid_conv got d=%h busy=%b el=%0d exp d=000 busy=0 el=0",
                           {min_d, sec_t, sec_o}, dut.u_conv.busy_o, elapsed_sec);
    end
    @(posedge clock); #1;
    reset = 0;
    model_reset();
    repeat (20) cyc();
    checks++;
    if ({min_d, sec_t, sec_o} !== 12'h000 || playing !== 1'b0) begin
      failures++; $display("FAIL after_reset got d=%h play=%b exp d=000 play=0", {min_d, sec_t, sec_o}, playing);
    end
  endtask

  initial begin
    test_reset();
    test_play_end();
    test_repeat();
    test_speed();
    test_seek();
    test_conflicts();
    test_random();
    test_digits();
    test_reset_mid_conv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
